// File: rtl/bus_master_if.sv
// bus_master_if: core-side single request to shared-bus master protocol with slave timeout
module bus_master_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_rw,
  input  logic [29:0] core_addr,
  input  logic [31:0] core_wr_data,
  output logic [31:0] core_rd_data,
  output logic        core_busy,
  output logic        core_done,
  output logic        core_err,
  output logic        req_n,
  input  logic        grnt_n,
  output logic [29:0] addr,
  output logic        as_n,
  output logic        rw,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  input  logic        rdy_n
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [1:0]       state;
  logic [TMO_W-1:0] cnt;
  logic             lat_rw;
  logic [29:0]      lat_addr;
  logic [31:0]      lat_wr_data;
  assign core_busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_n        <= 1'b1;
      as_n         <= 1'b1;
      addr         <= '0;
      wr_data      <= '0;
      rw           <= 1'b1;
      core_rd_data <= '0;
      core_done    <= 1'b0;
      core_err     <= 1'b0;
      lat_rw       <= 1'b1;
      lat_addr     <= '0;
      lat_wr_data  <= '0;
    end else begin
      core_done <= 1'b0;
      core_err  <= 1'b0;
      as_n      <= 1'b1;
      case (state)
        IDLE: if (core_req) begin
          lat_rw      <= core_rw;
          lat_addr    <= core_addr;
          lat_wr_data <= core_wr_data;
          req_n       <= 1'b0;
          state       <= REQ;
        end
        REQ: if (!grnt_n) begin
          addr    <= lat_addr;
          rw      <= lat_rw;
          wr_data <= lat_rw ? '0 : lat_wr_data;
          as_n    <= 1'b0;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: if (!rdy_n || cnt == CNT_LAST) begin
          // a ready on the limit edge still counts as a normal completion
          if (!rdy_n && rw) core_rd_data <= rd_data;
          core_done <= 1'b1;
          core_err  <= rdy_n;
          req_n     <= 1'b1;
          addr      <= '0;
          wr_data   <= '0;
          rw        <= 1'b1;
          state     <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed scenario tests for bus_master_if with TIMEOUT_CYCLES=8
module tb_bus_master_if;
  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic        core_rw;
  logic [29:0] core_addr;
  logic [31:0] core_wr_data;
  logic [31:0] core_rd_data;
  logic        core_busy;
  logic        core_done;
  logic        core_err;
  logic        req_n;
  logic        grnt_n;
  logic [29:0] addr;
  logic        as_n;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_n;
  int checks = 0;
  int failures = 0;

  bus_master_if #(.TIMEOUT_CYCLES(8), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_rw(core_rw),
    .core_addr(core_addr), .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
    .req_n(req_n), .grnt_n(grnt_n), .addr(addr), .as_n(as_n), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_n(rdy_n)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({req_n, as_n, rw, core_busy, core_done, core_err} !== 6'b111000 || addr !== 30'h0 ||
        wr_data !== 32'h0 || core_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_values got req_n=%b as_n=%b rw=%b busy=%b done=%b err=%b addr=%h wr=%h rd=%h exp 1 1 1 0 0 0 0 0 0",
               req_n, as_n, rw, core_busy, core_done, core_err, addr, wr_data, core_rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (core_busy !== 1'b0 || req_n !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b req_n=%b exp 0 1", core_busy, req_n);
    end
  endtask

  task automatic test_zero_wait_read(input logic [29:0] a, input logic [31:0] d);
    core_req = 1'b1; core_rw = 1'b1; core_addr = a;
    @(negedge clk);
    checks++;
    if (req_n !== 1'b0 || core_busy !== 1'b1 || as_n !== 1'b1) begin
      failures++;
      $display("FAIL read_req got req_n=%b busy=%b as_n=%b exp 0 1 1", req_n, core_busy, as_n);
    end
    core_req = 1'b0; grnt_n = 1'b0;
    @(negedge clk);
    checks++;
    if (as_n !== 1'b0 || addr !== a || rw !== 1'b1 || wr_data !== 32'h0) begin
      failures++;
      $display("FAIL read_strobe got as_n=%b addr=%h rw=%b wr=%h exp 0 %h 1 0", as_n, addr, rw, wr_data, a);
    end
    grnt_n = 1'b1; rdy_n = 1'b0; rd_data = d;
    @(negedge clk);
    rdy_n = 1'b1; rd_data = 32'h0;
    checks++;
    if (core_done !== 1'b1 || core_err !== 1'b0 || core_rd_data !== d || as_n !== 1'b1) begin
      failures++;
      $display("FAIL read_done got done=%b err=%b rd=%h as_n=%b exp 1 0 %h 1", core_done, core_err, core_rd_data, as_n, d);
    end
    checks++;
    if (req_n !== 1'b1 || addr !== 30'h0 || core_busy !== 1'b0) begin
      failures++;
      $display("FAIL read_release got req_n=%b addr=%h busy=%b exp 1 0 0", req_n, addr, core_busy);
    end
    @(negedge clk);
    checks++;
    if (core_done !== 1'b0) begin
      failures++;
      $display("FAIL read_done_pulse got done=%b exp 0", core_done);
    end
  endtask

  task automatic test_write_wait_states();
    core_req = 1'b1; core_rw = 1'b0; core_addr = 30'h20; core_wr_data = 32'h1234_5678;
    @(negedge clk);
    core_req = 1'b0; grnt_n = 1'b0;
    @(negedge clk);
    grnt_n = 1'b1;
    checks++;
    if (as_n !== 1'b0 || rw !== 1'b0 || addr !== 30'h20 || wr_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_strobe got as_n=%b rw=%b addr=%h wr=%h exp 0 0 20 12345678", as_n, rw, addr, wr_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (as_n !== 1'b1 || req_n !== 1'b0 || addr !== 30'h20 || wr_data !== 32'h1234_5678 || core_done !== 1'b0) begin
        failures++;
        $display("FAIL write_hold%0d got as_n=%b req_n=%b addr=%h wr=%h done=%b exp 1 0 20 12345678 0",
                 i, as_n, req_n, addr, wr_data, core_done);
      end
    end
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    checks++;
    if (core_done !== 1'b1 || core_err !== 1'b0 || core_rd_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_done got done=%b err=%b rd=%h exp 1 0 deadbeef", core_done, core_err, core_rd_data);
    end
    checks++;
    if (wr_data !== 32'h0 || rw !== 1'b1 || req_n !== 1'b1) begin
      failures++;
      $display("FAIL write_release got wr=%h rw=%b req_n=%b exp 0 1 1", wr_data, rw, req_n);
    end
  endtask

  task automatic test_delayed_grant();
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h55;
    @(negedge clk);
    core_addr = 30'h77;
    for (int i = 0; i < 10; i++) begin
      core_req = i[0];
      @(negedge clk);
      checks++;
      if (req_n !== 1'b0 || as_n !== 1'b1 || core_busy !== 1'b1) begin
        failures++;
        $display("FAIL grant_wait%0d got req_n=%b as_n=%b busy=%b exp 0 1 1", i, req_n, as_n, core_busy);
      end
    end
    core_req = 1'b0; grnt_n = 1'b0;
    @(negedge clk);
    grnt_n = 1'b1;
    checks++;
    if (as_n !== 1'b0 || addr !== 30'h55) begin
      failures++;
      $display("FAIL grant_addr got as_n=%b addr=%h exp 0 55", as_n, addr);
    end
    rdy_n = 1'b0; rd_data = 32'hCAFE_F00D;
    @(negedge clk);
    rdy_n = 1'b1;
    checks++;
    if (core_done !== 1'b1 || core_rd_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL grant_done got done=%b rd=%h exp 1 cafef00d", core_done, core_rd_data);
    end
    @(negedge clk);
    checks++;
    if (core_busy !== 1'b0 || req_n !== 1'b1) begin
      failures++;
      $display("FAIL grant_no_second got busy=%b req_n=%b exp 0 1", core_busy, req_n);
    end
  endtask

  task automatic test_timeout(input logic ready_last);
    core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h300;
    @(negedge clk);
    core_req = 1'b0; grnt_n = 1'b0;
    @(negedge clk);
    grnt_n = 1'b1; rd_data = 32'h0BAD_CAFE;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (core_done !== 1'b0 || core_busy !== 1'b1) begin
        failures++;
        $display("FAIL tmo_wait%0d got done=%b busy=%b exp 0 1", i, core_done, core_busy);
      end
    end
    rdy_n = ~ready_last;
    @(negedge clk);
    rdy_n = 1'b1;
    checks++;
    if (core_done !== 1'b1 || core_err !== ~ready_last || req_n !== 1'b1 || core_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_end got done=%b err=%b req_n=%b busy=%b exp 1 %b 1 0",
               core_done, core_err, req_n, core_busy, ~ready_last);
    end
    checks++;
    if (core_rd_data !== (ready_last ? 32'h0BAD_CAFE : 32'hCAFE_F00D)) begin
      failures++;
      $display("FAIL tmo_rd got rd=%h exp %h", core_rd_data, ready_last ? 32'h0BAD_CAFE : 32'hCAFE_F00D);
    end
    @(negedge clk);
    checks++;
    if (core_err !== 1'b0 || core_done !== 1'b0) begin
      failures++;
      $display("FAIL tmo_pulse got done=%b err=%b exp 0 0", core_done, core_err);
    end
  endtask

  task automatic test_reset_mid_access();
    core_req = 1'b1; core_rw = 1'b0; core_addr = 30'h44; core_wr_data = 32'hA5A5_A5A5;
    @(negedge clk);
    core_req = 1'b0; grnt_n = 1'b0;
    @(negedge clk);
    grnt_n = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({req_n, as_n, rw, core_busy, core_done} !== 5'b11100 || addr !== 30'h0 || wr_data !== 32'h0 ||
        core_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset got req_n=%b as_n=%b rw=%b busy=%b done=%b addr=%h wr=%h rd=%h exp 1 1 1 0 0 0 0 0",
               req_n, as_n, rw, core_busy, core_done, addr, wr_data, core_rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy_n = 1'b0;
      @(negedge clk);
      checks++;
      if (core_done !== 1'b0 || core_busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet%0d got done=%b busy=%b exp 0 0", i, core_done, core_busy);
      end
    end
    rdy_n = 1'b1;
  endtask

  initial begin
    core_req = 1'b0; core_rw = 1'b1; core_addr = '0; core_wr_data = '0;
    grnt_n = 1'b1; rdy_n = 1'b1; rd_data = '0;
    test_reset();
    test_zero_wait_read(30'h0000_0100, 32'hDEAD_BEEF);
    test_write_wait_states();
    test_delayed_grant();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_access();
    test_zero_wait_read(30'h3FFF_FFFF, 32'h1122_3344);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
